seq_match_window_monitor: RTL and testbench

- Sits directly downstream of the serial pattern detector and consumes its 1-cycle match pulse.
- Counts detector matches over a programmable window of N clock cycles, then reports three results:
  - the match count (saturating),
  - the 0-based cycle index of the first match,
  - a threshold alarm.
- Software or the test controller starts each window with a start pulse and reads the results when done pulses.

---
 rtl/seq_match_window_monitor_pkg.sv | 14 +
 rtl/seq_match_window_monitor_if.sv | 33 +++
 rtl/seq_match_window_monitor_sat_counter.sv | 39 +++
 rtl/seq_match_window_monitor.sv | 136 +++++++++++++
 tb/tb_seq_match_window_monitor.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/seq_match_window_monitor_pkg.sv
// Shared definitions for the match window monitor: state encoding and
// default widths used by the top, its interface and sub-modules.
package seq_match_window_monitor_pkg;

  localparam int DEF_CNT_W = 8;
  localparam int DEF_WIN_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    REPORT = 2'b10
  } state_t;

endpackage

// File: rtl/seq_match_window_monitor_if.sv
// Control/result bundle between the test controller (master) and the monitor (slave).
// Handshake: start is a one-cycle request honoured only while busy=0; done is a
// one-cycle pulse marking count/first_valid/first_pos/alarm as valid. match_in has no handshake.
interface seq_match_window_monitor_if
  import seq_match_window_monitor_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int WIN_W = DEF_WIN_W
) ();

  logic             start;
  logic [WIN_W-1:0] window_len;
  logic [CNT_W-1:0] threshold;
  logic             match_in;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] count;
  logic             first_valid;
  logic [WIN_W-1:0] first_pos;
  logic             alarm;
  state_t           state_dbg;

  modport master (
    output start, window_len, threshold, match_in,
    input  busy, done, count, first_valid, first_pos, alarm, state_dbg
  );

  modport slave (
    input  start, window_len, threshold, match_in,
    output busy, done, count, first_valid, first_pos, alarm, state_dbg
  );

endinterface

// File: rtl/seq_match_window_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// count_next exposes the value that will be registered at the coming edge.
module seq_match_window_monitor_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic [W-1:0] count_next
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count      = count_q;
  assign count_next = count_d;

endmodule

// File: rtl/seq_match_window_monitor.sv
// Counts detector match pulses over a programmable window and reports the
// saturated count, first-match cycle index and threshold alarm with a done pulse.
module seq_match_window_monitor
  import seq_match_window_monitor_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int WIN_W = DEF_WIN_W
) (
  input  logic                        clk,
  input  logic                        rst,
  seq_match_window_monitor_if.slave   mon
);

  localparam logic [WIN_W-1:0] WIN_ONE = WIN_W'(1);

  state_t           state_q, state_d;
  logic [WIN_W-1:0] len_q, len_d;
  logic [WIN_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] thr_q, thr_d;
  logic [WIN_W-1:0] first_pos_q, first_pos_d;
  logic             first_valid_q, first_valid_d;
  logic             alarm_q, alarm_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic             cnt_clr;
  logic             cnt_inc;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  seq_match_window_monitor_sat_counter #(
    .W (CNT_W)
  ) u_match_cnt (
    .clk        (clk),
    .rst        (rst),
    .clr        (cnt_clr),
    .inc        (cnt_inc),
    .count      (cnt),
    .count_next (cnt_next)
  );

  // Alarm is evaluated on the edge entering REPORT using the counter's next
  // value, so the final window cycle's match is included and alarm lines up with done.
  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    cyc_d         = cyc_q;
    thr_d         = thr_q;
    first_pos_d   = first_pos_q;
    first_valid_d = first_valid_q;
    alarm_d       = alarm_q;
    done_d        = 1'b0;
    cnt_clr       = 1'b0;
    cnt_inc       = 1'b0;

    case (state_q)
      IDLE: begin
        if (mon.start) begin
          len_d         = mon.window_len;
          thr_d         = mon.threshold;
          cyc_d         = '0;
          first_pos_d   = '0;
          first_valid_d = 1'b0;
          alarm_d       = 1'b0;
          cnt_clr       = 1'b1;
          if (mon.window_len != '0) begin
            state_d = RUN;
          end else begin
            state_d = REPORT;
            done_d  = 1'b1;
            alarm_d = (cnt_next >= mon.threshold);
          end
        end
      end

      RUN: begin
        cyc_d = cyc_q + WIN_ONE;
        if (mon.match_in) begin
          cnt_inc = 1'b1;
          if (!first_valid_q) begin
            first_valid_d = 1'b1;
            first_pos_d   = cyc_q;
          end
        end
        if (cyc_q == (len_q - WIN_ONE)) begin
          state_d = REPORT;
          done_d  = 1'b1;
          alarm_d = (cnt_next >= thr_q);
        end
      end

      REPORT: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      len_q         <= '0;
      cyc_q         <= '0;
      thr_q         <= '0;
      first_pos_q   <= '0;
      first_valid_q <= 1'b0;
      alarm_q       <= 1'b0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      cyc_q         <= cyc_d;
      thr_q         <= thr_d;
      first_pos_q   <= first_pos_d;
      first_valid_q <= first_valid_d;
      alarm_q       <= alarm_d;
      done_q        <= done_d;
      busy_q        <= busy_d;
    end
  end

  assign mon.busy        = busy_q;
  assign mon.done        = done_q;
  assign mon.count       = cnt;
  assign mon.first_valid = first_valid_q;
  assign mon.first_pos   = first_pos_q;
  assign mon.alarm       = alarm_q;
  assign mon.state_dbg   = state_q;

endmodule

// File: tb/tb_seq_match_window_monitor.sv
// Bench for seq_match_window_monitor: directed and random windows, results
// predicted from the match pattern and compared by a done-triggered monitor.
module tb_seq_match_window_monitor;
  import seq_match_window_monitor_pkg::*;

  localparam int CNT_W = 8;
  localparam int WIN_W = 16;
  localparam int EW    = CNT_W + WIN_W + 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  seq_match_window_monitor_if #(.CNT_W(CNT_W), .WIN_W(WIN_W)) mon_if ();

  seq_match_window_monitor #(.CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
    .clk (clk),
    .rst (rst),
    .mon (mon_if)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [EW-1:0] exp_q[$];
  int            exp_cyc_q[$];
  bit            mpat[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  function automatic logic [EW-1:0] result_vec();
    return {mon_if.alarm, mon_if.first_pos, mon_if.first_valid, mon_if.count};
  endfunction

  // Reference: count ones in the pattern, clip to the counter maximum, find the first one.
  function automatic logic [EW-1:0] model(input int n, input logic [CNT_W-1:0] thr);
    int hits  = 0;
    int first = -1;
    int maxc  = (1 << CNT_W) - 1;
    logic [CNT_W-1:0] c;
    logic             fv;
    logic [WIN_W-1:0] fp;
    for (int i = 0; i < n; i++) begin
      if (mpat[i]) begin
        hits++;
        if (first < 0) first = i;
      end
    end
    c  = CNT_W'((hits > maxc) ? maxc : hits);
    fv = (first >= 0);
    fp = fv ? WIN_W'(first) : '0;
    return {(c >= thr), fp, fv, c};
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    int            ec;
    if (!rst) begin
      if (mon_if.done) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 expected done=0 (cycle %0d)", cyc_cnt);
        end else begin
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          check("done_cycle", 64'(cyc_cnt), 64'(ec));
          check("result", 64'(result_vec()), 64'(e));
          check("busy_at_done", 64'(mon_if.busy), 64'(1));
        end
      end else if (exp_cyc_q.size() > 0 && cyc_cnt >= exp_cyc_q[0]) begin
        n_checks++;
        n_fail++;
        $display("FAIL missing_done: got done=0 expected done=1 at cycle %0d", exp_cyc_q[0]);
        void'(exp_q.pop_front());
        void'(exp_cyc_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Entered and left #1 after a rising edge in an IDLE cycle; start is raised in this cycle.
  task automatic run_window(input int n, input logic [CNT_W-1:0] thr);
    logic [EW-1:0] e;
    int t;
    t = cyc_cnt;
    e = model(n, thr);
    exp_q.push_back(e);
    exp_cyc_q.push_back(t + n + 1);
    mon_if.start      = 1'b1;
    mon_if.window_len = WIN_W'(n);
    mon_if.threshold  = thr;
    mon_if.match_in   = 1'($urandom_range(0, 1));
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        check("busy_in_run", 64'(mon_if.busy), 64'(1));
        check("cleared_at_start", 64'(result_vec()), 64'(0));
      end
      mon_if.start      = (i == 100) || ($urandom_range(0, 15) == 0);
      mon_if.window_len = WIN_W'($urandom);
      mon_if.threshold  = CNT_W'($urandom);
      mon_if.match_in   = mpat[i];
    end
    @(posedge clk); #1;
    mon_if.start    = 1'($urandom_range(0, 1));
    mon_if.match_in = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    mon_if.start    = 1'b0;
    mon_if.match_in = 1'($urandom_range(0, 1));
    check("idle_after_report", 64'({mon_if.busy, mon_if.done}), 64'(0));
    check("result_held", 64'(result_vec()), 64'(e));
  endtask

  task automatic reset_mid_window();
    mon_if.start      = 1'b1;
    mon_if.window_len = WIN_W'(8);
    mon_if.threshold  = CNT_W'(1);
    mon_if.match_in   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      mon_if.start    = 1'b0;
      mon_if.match_in = 1'b1;
    end
    @(posedge clk); #1;
    check("busy_before_reset", 64'(mon_if.busy), 64'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mon_if.match_in = 1'b0;
    check("outputs_after_mid_reset",
          64'({mon_if.busy, mon_if.done, result_vec(), mon_if.state_dbg}), 64'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [6:0] stream;
    logic [3:0] hist;
    int n;
    mon_if.start      = 1'b0;
    mon_if.window_len = '0;
    mon_if.threshold  = '0;
    mon_if.match_in   = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          64'({mon_if.busy, mon_if.done, result_vec(), mon_if.state_dbg}), 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // matches at cycles 2 and 5 of an 8-cycle window
    mpat.delete();
    for (int i = 0; i < 8; i++) mpat.push_back(i == 2 || i == 5);
    run_window(8, 8'd2);

    // first and last cycle of the window
    mpat.delete();
    for (int i = 0; i < 4; i++) mpat.push_back(i == 0 || i == 3);
    run_window(4, 8'd3);

    // zero-length windows
    mpat.delete();
    run_window(0, 8'd0);
    run_window(0, 8'd5);

    // empty window
    mpat.delete();
    for (int i = 0; i < 10; i++) mpat.push_back(1'b0);
    run_window(10, 8'd1);

    // saturation with a start pulse at RUN cycle 100
    mpat.delete();
    for (int i = 0; i < 300; i++) mpat.push_back(1'b1);
    run_window(300, 8'd255);

    reset_mid_window();
    mpat.delete();
    for (int i = 0; i < 5; i++) mpat.push_back(i == 1);
    run_window(5, 8'd0);

    // serial detector for 1101 (overlapping) feeding the monitor
    stream = 7'b1101101;
    hist   = '0;
    mpat.delete();
    for (int i = 0; i < 7; i++) begin
      hist = {hist[2:0], stream[6-i]};
      mpat.push_back(hist == 4'b1101);
    end
    run_window(7, 8'd2);

    // random windows
    for (int w = 0; w < 20; w++) begin
      int dens;
      n    = $urandom_range(1, 40);
      dens = $urandom_range(0, 4);
      mpat.delete();
      for (int i = 0; i < n; i++) mpat.push_back($urandom_range(0, 3) < dens);
      run_window(n, CNT_W'($urandom_range(0, 20)));
    end

    for (int k = 0; k < 100 && exp_q.size() > 0; k++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending results expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog expired");
  end

endmodule
